// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped buffered UART transmitter (8N1).
//
// The CPU pushes bytes through a 16-byte register window into a circular
// FIFO. A transmit engine drains the FIFO one frame at a time onto
// uart_txd. An optional level interrupt fires when the FIFO is empty and
// the engine is idle.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   WE        device-bus write enable
//   BE[3:0]   byte enables for the write
//   Addr[31:0] device-bus byte address
//   Din[31:0] write data
//   Dout[31:0] read data, combinational from Addr, 0 when not selected
//   uart_txd  serial output, idle high
//   IRQ       level interrupt request
//
// Register map (offset = Addr[3:2]):
//   0 DATA     write BE[0] pushes Din[7:0]; reads 0
//   1 STATUS   {count[10:4], ovf[3], empty[2], full[1], busy[0]}
//   2 DIVISOR  clock cycles per bit, 16 bits, byte-writable
//   3 CTRL     bit0 IE, bit1 flush (write-only), bit2 clear OVF (write-only)
module uart_tx_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F40,
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DIV_RESET = 16'd2604
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] Addr,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        uart_txd,
  output logic        IRQ
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // A divisor of 0 would stall the bit timer, so it is treated as 1.
  function automatic logic [15:0] clamp_bitlen(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  logic          sel;
  logic          wr_en;
  logic [1:0]    offset;
  logic          push_req;
  logic          ctrl_wr;
  logic          flush;
  logic          pop;
  logic          push_ok;
  logic          overflow;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  logic          ovf;
  logic          ie;
  logic [15:0]   divisor;

  state_t        state;
  logic [15:0]   timer;
  logic [15:0]   bitlen;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_done;

  logic          unused_bits;
  assign unused_bits = ^{Din[31:16], BE[3:2], Addr[1:0]};

  // ---- bus decode ----
  assign sel      = (Addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en    = WE & sel;
  assign offset   = Addr[3:2];
  assign push_req = wr_en & (offset == 2'd0) & BE[0];
  assign ctrl_wr  = wr_en & (offset == 2'd3) & BE[0];
  assign flush    = ctrl_wr & Din[1];

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  // The engine only pops from IDLE, so a push into an empty FIFO becomes
  // visible first and is popped on the following edge (no bypass).
  assign pop      = (state == S_IDLE) & ~empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req & ~flush & (~full | pop);
  assign overflow = push_req & ~flush & full & ~pop;

  assign bit_done = (timer == 16'd0);

  // ---- FIFO storage (data, not reset) ----
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= Din[7:0];
    end
  end

  // ---- FIFO pointers and occupancy ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- control registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf     <= 1'b0;
      ie      <= 1'b0;
      divisor <= DIV_RESET;
    end else begin
      if (overflow) begin
        ovf <= 1'b1;
      end else if (ctrl_wr & Din[2]) begin
        ovf <= 1'b0;
      end
      if (ctrl_wr) ie <= Din[0];
      if (wr_en && offset == 2'd2) begin
        if (BE[0]) divisor[7:0]  <= Din[7:0];
        if (BE[1]) divisor[15:8] <= Din[15:8];
      end
    end
  end

  // ---- transmit shift register (data, not reset) ----
  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= mem[rd_ptr];
    end else if (state == S_DATA && bit_done) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  // ---- transmit engine ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      uart_txd <= 1'b1;
      timer    <= 16'd0;
      bitlen   <= 16'd1;
      bit_idx  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          uart_txd <= 1'b1;
          if (pop) begin
            // bitlen is latched here so divisor writes apply per frame.
            bitlen   <= clamp_bitlen(divisor);
            timer    <= clamp_bitlen(divisor) - 16'd1;
            uart_txd <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            timer    <= bitlen - 16'd1;
            bit_idx  <= 3'd0;
            uart_txd <= shift[0];
            state    <= S_DATA;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            timer <= bitlen - 16'd1;
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= S_STOP;
            end else begin
              // shift[0] is being retired this edge; shift[1] is next.
              uart_txd <= shift[1];
              bit_idx  <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            state <= S_IDLE;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- interrupt ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= ie & empty & (state == S_IDLE);
    end
  end

  // ---- read mux ----
  always_comb begin
    Dout = '0;
    if (sel) begin
      case (offset)
        2'd1:    Dout = {21'b0, 7'(count), ovf, empty, full, (state != S_IDLE)};
        2'd2:    Dout = {16'b0, divisor};
        2'd3:    Dout = {31'b0, ie};
        default: Dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: register reads after reset, frame
// timing and bit order, FIFO overflow, interrupt behaviour, divisor
// handling, flush, and asynchronous reset mid-frame.
module tb_uart_tx_fifo;

  localparam logic [31:0] A_DATA   = 32'h0000_7F40;
  localparam logic [31:0] A_STATUS = 32'h0000_7F44;
  localparam logic [31:0] A_DIV    = 32'h0000_7F48;
  localparam logic [31:0] A_CTRL   = 32'h0000_7F4C;
  localparam logic [31:0] A_OTHER  = 32'h0000_7F54;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WE = 1'b0;
  logic [3:0]  BE = 4'h0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] Din = 32'h0;
  logic [31:0] Dout;
  logic        uart_txd;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo #(
    .BASE_ADDR(32'h0000_7F40),
    .DEPTH(16),
    .DIV_RESET(16'd2604)
  ) dut (
    .clk(clk),
    .reset(reset),
    .WE(WE),
    .BE(BE),
    .Addr(Addr),
    .Din(Din),
    .Dout(Dout),
    .uart_txd(uart_txd),
    .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the write is captured on the next edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    Addr = a;
    Din  = d;
    BE   = be;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
    BE = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  // Waits (bounded) for a start bit, then checks every cycle of a 10*bitlen
  // frame plus the following idle cycle.
  task automatic expect_frame(input string tag, input logic [7:0] b, input int bitlen,
                              input int max_wait, input bit chk_busy);
    int   waited = 0;
    int   bad = 0;
    int   bbad = 0;
    int   ibad = 0;
    logic found = 1'b0;
    if (chk_busy) Addr = A_STATUS;
    while (!found && waited < max_wait) begin
      @(negedge clk);
      waited++;
      if (uart_txd === 1'b0) found = 1'b1;
    end
    check_val({tag, "_start"}, 32'(found), 32'd1);
    if (found) begin
      for (int c = 0; c < 10 * bitlen; c++) begin
        int   slot;
        logic e;
        if (c > 0) @(negedge clk);
        slot = c / bitlen;
        if (slot == 0)      e = 1'b0;
        else if (slot == 9) e = 1'b1;
        else                e = b[3'(slot - 1)];
        if (uart_txd !== e) bad++;
        if (chk_busy && Dout[0] !== 1'b1) bbad++;
        if (IRQ !== 1'b0) ibad++;
      end
      check_val({tag, "_bits"}, 32'(bad), 32'd0);
      check_val({tag, "_irq"}, 32'(ibad), 32'd0);
      if (chk_busy) check_val({tag, "_busy"}, 32'(bbad), 32'd0);
      @(negedge clk);
      check_val({tag, "_gap"}, 32'(uart_txd), 32'd1);
      if (chk_busy) check_val({tag, "_gapbusy"}, 32'(Dout[0]), 32'd0);
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int   n = 0;
    logic done = 1'b0;
    Addr = A_STATUS;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
      if (Dout[0] === 1'b0 && Dout[2] === 1'b1) done = 1'b1;
    end
    check_val({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check_val(tag, 32'(lows), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_txd", 32'(uart_txd), 32'd1);
    check_val("rst_irq", 32'(IRQ), 32'd0);
    bus_read(A_STATUS, rd); check_val("rst_status", rd, 32'h4);
    bus_read(A_DIV, rd);    check_val("rst_div", rd, 32'd2604);
    bus_read(A_CTRL, rd);   check_val("rst_ctrl", rd, 32'h0);
    bus_read(A_DATA, rd);   check_val("rst_data", rd, 32'h0);
    bus_read(A_OTHER, rd);  check_val("unsel_read", rd, 32'h0);

    // Single frame 0xA5, divisor 4, with latency
    sync_edge();
    bus_write(A_DIV, 32'd4, 4'b0011);
    bus_write(A_DATA, 32'hA5, 4'b0001);
    @(negedge clk);
    check_val("lat_pre", 32'(uart_txd), 32'd1);
    expect_frame("a5", 8'hA5, 4, 1, 1'b1);
    bus_read(A_DIV, rd); check_val("div4_read", rd, 32'd4);

    // Overflow: 0xFF occupies the engine, then 17 pushes
    sync_edge();
    bus_write(A_DIV, 32'd2, 4'b0011);
    bus_write(A_DATA, 32'hFF, 4'b0001);
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 32'(i), 4'b0001);
    bus_read(A_STATUS, rd); check_val("ovf_status", rd, 32'h10B);
    for (int i = 0; i < 16; i++)
      expect_frame($sformatf("q%0d", i), 8'(i), 2, (i == 0) ? 12 : 3, 1'b1);
    bus_read(A_STATUS, rd); check_val("drained_status", rd, 32'hC);
    sync_edge();
    bus_write(A_CTRL, 32'h4, 4'b0001);
    bus_read(A_STATUS, rd); check_val("ovf_clear", rd, 32'h4);

    // Interrupt
    sync_edge();
    bus_write(A_DIV, 32'd3, 4'b0011);
    bus_write(A_CTRL, 32'h1, 4'b0001);
    bus_write(A_DATA, 32'h5A, 4'b0001);
    expect_frame("irq5a", 8'h5A, 3, 3, 1'b1);
    check_val("irq_gap", 32'(IRQ), 32'd0);
    @(negedge clk);
    check_val("irq_set", 32'(IRQ), 32'd1);
    sync_edge();
    bus_write(A_DATA, 32'h81, 4'b0001);
    @(negedge clk);
    check_val("irq_hold", 32'(IRQ), 32'd1);
    @(negedge clk);
    check_val("irq_drop", 32'(IRQ), 32'd0);
    wait_idle("irq81", 200);
    @(negedge clk);
    check_val("irq_again", 32'(IRQ), 32'd1);
    sync_edge();
    bus_write(A_CTRL, 32'h0, 4'b0001);
    bus_read(A_CTRL, rd); check_val("ie_off", rd, 32'h0);

    // Divisor 0 acts as 1; a mid-frame divisor write waits for next frame
    sync_edge();
    bus_write(A_DIV, 32'd0, 4'b0011);
    fork
      expect_frame("div0", 8'hFF, 1, 4, 1'b0);
      begin
        bus_write(A_DATA, 32'hFF, 4'b0001);
        sync_edge();
        bus_write(A_DIV, 32'd3, 4'b0011);
      end
    join
    bus_read(A_STATUS, rd); check_val("div0_idle", rd, 32'h4);
    bus_read(A_DIV, rd);    check_val("div3_read", rd, 32'd3);
    sync_edge();
    bus_write(A_DATA, 32'h0F, 4'b0001);
    expect_frame("div3", 8'h0F, 3, 3, 1'b1);

    // Flush while a frame is in flight
    sync_edge();
    bus_write(A_DIV, 32'd2, 4'b0011);
    fork
      expect_frame("fl_cur", 8'h11, 2, 6, 1'b0);
      begin
        for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'((i + 1) * 17), 4'b0001);
        bus_write(A_CTRL, 32'h2, 4'b0001);
      end
    join
    bus_read(A_STATUS, rd); check_val("flush_status", rd, 32'h4);
    watch_quiet("flush_quiet", 30);

    // Asynchronous reset mid-frame
    sync_edge();
    bus_write(A_DIV, 32'd4, 4'b0011);
    bus_write(A_DATA, 32'h00, 4'b0001);
    repeat (3) @(posedge clk);
    #3;
    check_val("rst_pre", 32'(uart_txd), 32'd0);
    reset = 1'b1;
    #1;
    check_val("rst_async_txd", 32'(uart_txd), 32'd1);
    check_val("rst_async_irq", 32'(IRQ), 32'd0);
    #2;
    reset = 1'b0;
    bus_read(A_STATUS, rd); check_val("rst2_status", rd, 32'h4);
    bus_read(A_DIV, rd);    check_val("rst2_div", rd, 32'd2604);
    watch_quiet("rst2_quiet", 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
